i2s_tx_sequencer: RTL
=====================

Name: i2s_tx_sequencer

Overview:
Drives one stereo I2S transmit slot stream into the existing `i2s_bus` serializer. It generates `sclk` and `lr_clk` from the system clock and pulls 32-bit samples from an upstream valid/ready stream in strict L,R,L,R order. It presents each sample on `bit_data` at its slot boundary and flags underruns. It sits between the mic/beamformer sample path and `i2s_bus`.

Parameters:
- CLK_DIV, 5: clk cycles per sclk half-period; legal range >=2. One bit lasts 2*CLK_DIV cycles.
- WIDTH, 32: bits per slot, which is also the sample width. Legal range >=2.
- UCNT_W, 16: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run request
- s_data  in  WIDTH  upstream sample; strict L,R alternation
- s_valid  in  1  upstream sample valid
- s_ready  out  1  sequencer can accept a sample this cycle
- sclk  out  1  I2S bit clock
- lr_clk  out  1  word select; 0 = left slot, 1 = right slot
- bit_data  out  WIDTH  current slot word to `i2s_bus`
- load  out  1  one-cycle pulse when `bit_data`/`lr_clk` update at a slot start
- underrun  out  1  one-cycle pulse when a slot starts with no sample buffered
- underrun_cnt  out  UCNT_W  count of underruns; saturates at all-ones
- busy  out  1  high in PRIME or RUN

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `rst`.
- Reset values: all outputs 0, including `s_ready`, `sclk`, `lr_clk`, `bit_data`, `load`, `underrun`, `underrun_cnt` and `busy`. State is IDLE, the one-entry prefetch buffer is empty, `div_cnt` = 0, `bit_cnt` = 0.
- Reset asserted mid-frame: immediate return to the reset values. The buffer is flushed and `underrun_cnt` clears.
- Prefetch buffer: one entry.
  - `s_ready` = busy && (!buf_full || slot_end_this_cycle).
  - A transfer is `s_valid` && `s_ready`.
  - A simultaneous drain at the slot end and accept of a new sample is allowed; the buffer stays full with the new word.
- State IDLE: `sclk` = 0, `lr_clk` = 0, `s_ready` = 0. When `enable` = 1, go to PRIME next cycle.
- State PRIME:
  - `s_ready` follows the buffer rule above.
  - Wait indefinitely for `buf_full`.
  - On the cycle `buf_full` = 1: `bit_data` <= buffer, `lr_clk` <= 0, `load` = 1, buffer empties, `div_cnt` = 0, `bit_cnt` = 0, go to RUN.
  - If `enable` drops while in PRIME, go to IDLE and flush the buffer.
- State RUN, clock generation:
  - `div_cnt` counts 0..CLK_DIV-1; at the wrap, `sclk` toggles.
  - A falling toggle of `sclk` is a bit boundary; `bit_cnt` increments there.
- State RUN, slot end: the bit boundary where `bit_cnt` == WIDTH-1. On that same cycle, registered together:
  - `sclk` -> 0, `bit_cnt` -> 0, `lr_clk` toggles, `load` = 1.
  - If the buffer is full: `bit_data` <= buffer.
  - Else: `bit_data` <= 0, `underrun` = 1, `underrun_cnt` += 1 (saturating at all-ones).
  - An underrun still consumes the slot, so L/R alignment of later samples is preserved.
- Slot timing: slot length = 2*CLK_DIV*WIDTH cycles; frame length = 2 slots. At defaults these are 320 and 640 cycles.
- `enable` deasserted in RUN:
  - The current frame completes: continue until the slot end that would begin a left slot (`lr_clk` 1 -> 0).
  - At that point, instead of loading, go to IDLE: `sclk` = 0, `lr_clk` = 0, `bit_data` holds its last value, `load` = 0, no underrun.
  - The buffer is flushed.
  - `enable` re-asserted before that point cancels the stop.
- `busy` = 1 in PRIME and RUN.

Optional Feature:
- Macro: I2S_HOLD_LAST_EN.
- Defined: on underrun, `bit_data` <= the last word loaded for the same channel (left or right), using one stored word per channel. The `underrun` pulse and `underrun_cnt` still update. The stored words reset to 0.
- Undefined: on underrun, `bit_data` <= 0.

Test Plan:
1. Startup and first frame: reset, `enable` = 1, push 32'hA5A5A5A5 then 32'h5A5A5A5A with `s_valid` held -> `load` pulse with `bit_data` = A5A5A5A5 and `lr_clk` = 0. 320 cycles later: `load`, `lr_clk` = 1, `bit_data` = 5A5A5A5A. `sclk` period is 10 cycles.
2. Underrun: after the first L sample, hold `s_valid` = 0 -> at the R slot start, `underrun` pulses, `bit_data` = 0 and `underrun_cnt` = 1. A sample pushed next appears in the following L slot. With I2S_HOLD_LAST_EN, the R slot instead carries the previous R word.
3. Backpressure: `s_valid` held high continuously -> exactly one transfer per slot after priming. `s_ready` is 0 while the buffer is full, except on slot-end cycles.
4. Stop mid-frame: drop `enable` during the L slot -> the R slot completes, then `sclk` = `lr_clk` = 0 and `busy` = 0. No spurious `load` or `underrun`.
5. Reset mid-RUN: assert `rst` for 1 cycle at `bit_cnt` = 17 -> the next cycle shows all outputs 0 and state IDLE. Re-enable restarts cleanly from PRIME.
6. Counter saturation: UCNT_W = 2 with no input after priming -> `underrun_cnt` reaches 3 and stays at 3 while `underrun` keeps pulsing every slot.

Source files
------------

// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer: generates sclk/lr_clk from clk. It pulls 32-bit samples in
// L,R order from an upstream stream through a one-entry prefetch buffer and
// presents each one on bit_data at its slot start. When a slot starts with no
// sample buffered, the slot still runs and the underrun is flagged and counted.
//
// Optional build macro I2S_HOLD_LAST_EN: an underrun slot repeats the last word
// loaded for that channel instead of sending zero.
//
// Handshake: a sample transfers on a clk edge where s_valid && s_ready. s_valid
// may be asserted at any time. s_ready never depends on s_valid. A transfer on
// the slot-end cycle refills the buffer while the old word drains to bit_data.
module i2s_tx_sequencer #(
  parameter int CLK_DIV = 5,
  parameter int WIDTH   = 32,
  parameter int UCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sclk,
  output logic              lr_clk,
  output logic [WIDTH-1:0]  bit_data,
  output logic              load,
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // FSM state is kept as a named signal so checkers can bind to it.
  state_t state;

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic [WIDTH-1:0] fill_word;

  logic div_wrap;
  logic slot_end;
  logic stopping;
  logic prime_load;
  logic xfer;
  logic drain;
  logic flush;

`ifdef I2S_HOLD_LAST_EN
  logic [WIDTH-1:0] last_l;
  logic [WIDTH-1:0] last_r;
  // The next slot is left when lr_clk is currently 1.
  assign fill_word = lr_clk ? last_l : last_r;
`else
  assign fill_word = '0;
`endif

  // A slot ends on the falling sclk toggle that closes its final bit.
  assign div_wrap   = (div_cnt == DIV_LAST);
  assign slot_end   = (state == ST_RUN) && div_wrap && sclk && (bit_cnt == BIT_LAST);
  // Stop only at the boundary that would start a new left slot, so frames finish.
  assign stopping   = slot_end && lr_clk && !enable;
  assign prime_load = (state == ST_PRIME) && enable && buf_full;

  assign busy    = (state != ST_IDLE);
  assign s_ready = busy && (!buf_full || slot_end);
  assign xfer    = s_valid && s_ready;
  assign drain   = prime_load || (slot_end && !stopping);
  assign flush   = ((state == ST_PRIME) && !enable) || stopping;

  // Prefetch buffer: flush beats refill, and refill beats drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (flush) begin
      buf_full <= 1'b0;
    end else if (xfer) begin
      buf_full <= 1'b1;
      buf_data <= s_data;
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  // Sequencer FSM: clock generation, slot loads, underrun flagging and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      sclk         <= 1'b0;
      lr_clk       <= 1'b0;
      bit_data     <= '0;
      load         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
`ifdef I2S_HOLD_LAST_EN
      last_l       <= '0;
      last_r       <= '0;
`endif
    end else begin
      load     <= 1'b0;
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          sclk    <= 1'b0;
          lr_clk  <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (enable) state <= ST_PRIME;
        end
        ST_PRIME: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (buf_full) begin
            bit_data <= buf_data;
            lr_clk   <= 1'b0;
            load     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            state    <= ST_RUN;
`ifdef I2S_HOLD_LAST_EN
            last_l   <= buf_data;
`endif
          end
        end
        ST_RUN: begin
          if (!div_wrap) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt != BIT_LAST) begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              sclk    <= 1'b0;
              bit_cnt <= '0;
              if (stopping) begin
                state  <= ST_IDLE;
                lr_clk <= 1'b0;
              end else begin
                lr_clk <= ~lr_clk;
                load   <= 1'b1;
                if (buf_full) begin
                  bit_data <= buf_data;
`ifdef I2S_HOLD_LAST_EN
                  if (lr_clk) last_l <= buf_data;
                  else        last_r <= buf_data;
`endif
                end else begin
                  bit_data <= fill_word;
                  underrun <= 1'b1;
                  if (underrun_cnt != {UCNT_W{1'b1}})
                    underrun_cnt <= underrun_cnt + UCNT_W'(1);
                end
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
